esc_clk_seq: RTL and testbench



---
 rtl/esc_clk_pkg.sv | 27 ++
 rtl/esc_sync_2ff.sv | 32 +++
 rtl/esc_clk_seq.sv | 159 +++++++++++++++
 tb/tb_esc_clk_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/esc_clk_pkg.sv
// Shared types and defaults for the MMCM bring-up sequencer.
//   state_t : sequencer state encoding, also exported on state_o for debug
//   *_DEF   : default timing parameters for a 125 MHz board clock
package esc_clk_pkg;

  typedef enum logic [2:0] {
    RST1  = 3'd0,
    WAIT1 = 3'd1,
    RST2  = 3'd2,
    WAIT2 = 3'd3,
    RUN   = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam int RST_PULSE_DEF    = 16;
  localparam int HOLDOFF_DEF      = 64;
  localparam int LOCK_TIMEOUT_DEF = 125000;
  localparam int MAX_RETRY_DEF    = 3;

  // Largest of three values; sizes the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/esc_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous inputs
//   q   : synchronised outputs, 2 cycles of latency
module esc_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync;

  // NOTE: synchroniser flops are reset to 0 so a lock reads as "not locked"
  // until it has been seen high after reset; no stale lock survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/esc_clk_seq.sv
// Bring-up and supervision sequencer for two cascaded MMCM stages.
// Releases stage-1 then stage-2 reset, waits for each lock with a holdoff
// and a timeout, and holds the control-domain reset request until RUN.
// In RUN a lock loss re-sequences only the affected stage; repeated lock
// timeouts latch FAULT until fault_clr.
//   clk_125_in   : free-running board clock
//   rst          : asynchronous active-high reset
//   mmcm1_locked : stage-1 lock (asynchronous)
//   mmcm2_locked : stage-2 lock (asynchronous)
//   fault_clr    : one-cycle pulse, leaves FAULT
//   mmcm1_rst    : stage-1 MMCM reset
//   mmcm2_rst    : stage-2 MMCM reset
//   ctrl_rst_req : reset request to the clk_ctrl domain
//   clk_ready    : high in RUN
//   fault        : high in FAULT
//   state_o      : current state (debug)
//   retry_cnt    : consecutive lock timeouts in the current attempt
//   loss_cnt     : lock-loss events seen in RUN, saturating
module esc_clk_seq
  import esc_clk_pkg::*;
#(
  parameter int RST_PULSE    = RST_PULSE_DEF,
  parameter int HOLDOFF      = HOLDOFF_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic       clk_125_in,
  input  logic       rst,
  input  logic       mmcm1_locked,
  input  logic       mmcm2_locked,
  input  logic       fault_clr,
  output logic       mmcm1_rst,
  output logic       mmcm2_rst,
  output logic       ctrl_rst_req,
  output logic       clk_ready,
  output logic       fault,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int CNT_W = $clog2(max3(LOCK_TIMEOUT, HOLDOFF, RST_PULSE) + 1);

  // Counters compare against N-1: the transition fires on the N-th cycle.
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);

  logic [1:0]       lk_sync;
  logic             l1s, l2s, lk;
  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] to_cnt, to_n;
  logic [1:0]       retry_n;
  logic [7:0]       loss_n;

  esc_sync_2ff #(.WIDTH(2)) u_lock_sync (
    .clk (clk_125_in),
    .rst (rst),
    .d   ({mmcm2_locked, mmcm1_locked}),
    .q   (lk_sync)
  );

  assign l1s = lk_sync[0];
  assign l2s = lk_sync[1];

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    timer_n = timer;
    to_n    = to_cnt;
    retry_n = retry_cnt;
    loss_n  = loss_cnt;
    lk      = (state == WAIT2) ? l2s : l1s;

    case (state)
      RST1, RST2: begin
        if (timer == PULSE_LAST) begin
          state_n = (state == RST1) ? WAIT1 : WAIT2;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      WAIT1, WAIT2: begin
        timer_n = '0;
        to_n    = '0;
        if (state == WAIT2 && !l1s) begin
          // Upstream clock vanished: restart from stage 1, not a timeout.
          state_n = RST1;
        end else if (lk && timer == HOLD_LAST) begin
          // Holdoff completion wins over a coincident timeout.
          state_n = (state == WAIT1) ? RST2 : RUN;
          retry_n = '0;
        end else if (to_cnt == TO_LAST) begin
          retry_n = retry_cnt + 2'd1;
          if (retry_n == RETRY_MAX) state_n = FAULT;
          else                      state_n = (state == WAIT1) ? RST1 : RST2;
        end else begin
          timer_n = lk ? timer + 1'b1 : '0;
          to_n    = to_cnt + 1'b1;
        end
      end

      RUN: begin
        // A simultaneous loss of both locks is one stage-1 loss.
        if (!l1s || !l2s) begin
          state_n = !l1s ? RST1 : RST2;
          if (loss_cnt != 8'hFF) loss_n = loss_cnt + 8'd1;
        end
      end

      FAULT: begin
        if (fault_clr) begin
          state_n = RST1;
          retry_n = '0;
        end
      end

      default: state_n = RST1;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as state_o.
  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_125_in or posedge rst) begin
    if (rst) begin
      state        <= RST1;
      timer        <= '0;
      to_cnt       <= '0;
      retry_cnt    <= '0;
      loss_cnt     <= '0;
      mmcm1_rst    <= 1'b1;
      mmcm2_rst    <= 1'b1;
      ctrl_rst_req <= 1'b1;
      clk_ready    <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      to_cnt       <= to_n;
      retry_cnt    <= retry_n;
      loss_cnt     <= loss_n;
      mmcm1_rst    <= (state_n == RST1) || (state_n == FAULT);
      mmcm2_rst    <= (state_n inside {RST1, WAIT1, RST2, FAULT});
      ctrl_rst_req <= (state_n != RUN);
      clk_ready    <= (state_n == RUN);
      fault        <= (state_n == FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_esc_clk_seq.sv
module tb_esc_clk_seq;
  import esc_clk_pkg::*;

  localparam int RP = 4;
  localparam int HO = 8;
  localparam int LT = 50;
  localparam int MR = 3;

  logic       clk_125_in = 1'b0;
  logic       rst = 1'b1;
  logic       mmcm1_locked = 1'b0;
  logic       mmcm2_locked = 1'b0;
  logic       fault_clr = 1'b0;
  logic       mmcm1_rst, mmcm2_rst, ctrl_rst_req, clk_ready, fault;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  esc_clk_seq #(
    .RST_PULSE(RP), .HOLDOFF(HO), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR)
  ) dut (
    .clk_125_in   (clk_125_in),
    .rst          (rst),
    .mmcm1_locked (mmcm1_locked),
    .mmcm2_locked (mmcm2_locked),
    .fault_clr    (fault_clr),
    .mmcm1_rst    (mmcm1_rst),
    .mmcm2_rst    (mmcm2_rst),
    .ctrl_rst_req (ctrl_rst_req),
    .clk_ready    (clk_ready),
    .fault        (fault),
    .state_o      (state_o),
    .retry_cnt    (retry_cnt),
    .loss_cnt     (loss_cnt)
  );

  always #4 clk_125_in = ~clk_125_in;

  // {state, mmcm1_rst, mmcm2_rst, ctrl_rst_req, clk_ready, fault, retry, loss}
  logic [17:0] dut_vec;
  assign dut_vec = {state_o, mmcm1_rst, mmcm2_rst, ctrl_rst_req, clk_ready,
                    fault, retry_cnt, loss_cnt};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pin levels per state: {mmcm1_rst, mmcm2_rst, ctrl_rst_req, clk_ready, fault}
  localparam logic [4:0] PINS [6] = '{5'b11100, 5'b01100, 5'b01100,
                                      5'b00100, 5'b00010, 5'b11101};

  function automatic logic [17:0] pack(input int st, input int r, input int l);
    return {3'(st), PINS[st], 2'(r), 8'(l)};
  endfunction

  // Reference model: elapsed cycles in the current phase, length of the
  // current run of synchronised-high lock samples, retry and loss tallies.
  // Lock inputs reach the sequencer two edges after they are sampled.
  int   m_st, m_age, m_hi, m_retry, m_loss;
  logic h1 [2];
  logic h2 [2];

  task automatic model_go(input int s);
    m_st  = s;
    m_age = 0;
    m_hi  = 0;
  endtask

  task automatic model_reset();
    model_go(0);
    m_retry = 0;
    m_loss  = 0;
    h1 = '{1'b0, 1'b0};
    h2 = '{1'b0, 1'b0};
  endtask

  task automatic model_lost(input int to);
    if (m_loss < 255) m_loss++;
    model_go(to);
  endtask

  task automatic model_step();
    logic s1, s2, seen;
    s1 = h1[1];
    s2 = h2[1];
    case (m_st)
      0, 2: begin
        m_age++;
        if (m_age == RP) model_go(m_st + 1);
      end
      1, 3: begin
        if (m_st == 3 && !s1) model_go(0);
        else begin
          m_age++;
          seen = (m_st == 1) ? s1 : s2;
          m_hi = seen ? m_hi + 1 : 0;
          if (m_hi == HO) begin
            m_retry = 0;
            model_go(m_st == 1 ? 2 : 4);
          end else if (m_age == LT) begin
            m_retry++;
            model_go(m_retry == MR ? 5 : (m_st == 1 ? 0 : 2));
          end
        end
      end
      4: begin
        if (!s1)      model_lost(0);
        else if (!s2) model_lost(2);
      end
      5: if (fault_clr) begin
        m_retry = 0;
        model_go(0);
      end
      default: model_go(0);
    endcase
    h1[1] = h1[0]; h1[0] = mmcm1_locked;
    h2[1] = h2[0]; h2[0] = mmcm2_locked;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare all outputs 1 ns later.
  task automatic tick();
    @(posedge clk_125_in);
    if (rst) model_reset();
    else     model_step();
    #1;
    check("cycle", dut_vec, pack(m_st, m_retry, m_loss));
  endtask

  typedef struct {
    string       name;
    logic        l1;
    logic        l2;
    logic        clr;
    int          n;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic l1, input logic l2,
                     input logic clr, input int n, input logic [17:0] exp);
    vec_t v;
    v.name = name; v.l1 = l1; v.l2 = l2; v.clr = clr; v.n = n; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      mmcm1_locked = tbl[i].l1;
      mmcm2_locked = tbl[i].l2;
      fault_clr    = tbl[i].clr;
      repeat (tbl[i].n) tick();
      check(tbl[i].name, dut_vec, tbl[i].exp);
    end
    fault_clr = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int k;
    k = 0;
    while (m_st != 4 && k < 300) begin
      tick();
      k++;
    end
    if (m_st != 4) check(name, dut_vec, pack(4, 0, m_loss));
  endtask

  task automatic release_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  int seq_a_end;
  int p1, p2;

  initial begin
    // Nominal bring-up, stage-2 loss, double loss, glitchy stage-1 lock.
    add("rst1_pulse",    0, 0, 0, 3, pack(0, 0, 0));
    add("wait1_entry",   0, 0, 0, 1, pack(1, 0, 0));
    add("wait1_idle",    0, 0, 0, 6, pack(1, 0, 0));
    add("l1_holdoff",    1, 0, 0, 9, pack(1, 0, 0));
    add("rst2_entry",    1, 0, 0, 1, pack(2, 0, 0));
    add("rst2_pulse",    1, 0, 0, 3, pack(2, 0, 0));
    add("wait2_entry",   1, 0, 0, 1, pack(3, 0, 0));
    add("wait2_idle",    1, 0, 0, 4, pack(3, 0, 0));
    add("l2_holdoff",    1, 1, 0, 9, pack(3, 0, 0));
    add("run_entry",     1, 1, 0, 1, pack(4, 0, 0));
    add("l2_drop",       1, 0, 0, 2, pack(4, 0, 0));
    add("l2_loss",       1, 0, 0, 1, pack(2, 0, 1));
    add("l2_back",       1, 1, 0, 4, pack(3, 0, 1));
    add("rerun_hold",    1, 1, 0, 7, pack(3, 0, 1));
    add("rerun",         1, 1, 0, 1, pack(4, 0, 1));
    add("both_drop",     0, 0, 0, 2, pack(4, 0, 1));
    add("l1_loss",       0, 0, 0, 1, pack(0, 0, 2));
    add("rst1_again",    0, 0, 0, 4, pack(1, 0, 2));
    add("glitch_hi",     1, 0, 0, 6, pack(1, 0, 2));
    add("glitch_lo",     0, 0, 0, 1, pack(1, 0, 2));
    add("glitch_rehold", 1, 0, 0, 9, pack(1, 0, 2));
    add("glitch_done",   1, 0, 0, 1, pack(2, 0, 2));
    add("to_wait2",      1, 0, 0, 4, pack(3, 0, 2));
    seq_a_end = tbl.size();
    // Lock timeouts into FAULT, then fault_clr.
    add("to_wait1",      0, 0, 0, 4,  pack(1, 0, 0));
    add("to_count1",     0, 0, 0, 49, pack(1, 0, 0));
    add("to_retry1",     0, 0, 0, 1,  pack(0, 1, 0));
    add("to_wait1b",     0, 0, 0, 4,  pack(1, 1, 0));
    add("to_count2",     0, 0, 0, 49, pack(1, 1, 0));
    add("to_retry2",     0, 0, 0, 1,  pack(0, 2, 0));
    add("to_wait1c",     0, 0, 0, 4,  pack(1, 2, 0));
    add("to_count3",     0, 0, 0, 49, pack(1, 2, 0));
    add("to_fault",      0, 0, 0, 1,  pack(5, 3, 0));
    add("fault_hold",    0, 0, 0, 5,  pack(5, 3, 0));
    add("fault_clr",     0, 0, 1, 1,  pack(0, 0, 0));
    add("after_clr",     0, 0, 0, 1,  pack(0, 0, 0));

    model_reset();
    release_reset();
    check("reset_state", dut_vec, pack(0, 0, 0));
    run_range(0, seq_a_end);

    // Reset mid-WAIT2 must clear outputs before the next clock edge.
    #2 rst = 1'b1;
    #1 check("async_rst", dut_vec, pack(0, 0, 0));
    release_reset();
    run_range(seq_a_end, tbl.size());

    // Saturate loss_cnt with repeated stage-2 drops.
    mmcm1_locked = 1'b1;
    mmcm2_locked = 1'b1;
    wait_run("first_run");
    for (int i = 0; i < 258; i++) begin
      mmcm2_locked = 1'b0;
      repeat (3) tick();
      mmcm2_locked = 1'b1;
      wait_run("sat_run");
    end
    check("loss_sat", dut_vec, pack(4, 0, 255));

    // Randomised lock behaviour, fault clears and occasional resets.
    for (int blk = 0; blk < 8; blk++) begin
      case ($urandom_range(2))
        0:       begin p1 = 3;   p2 = 3;   end
        1:       begin p1 = 25;  p2 = 15;  end
        default: begin p1 = 200; p2 = 100; end
      endcase
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(p1) == 0) mmcm1_locked = ~mmcm1_locked;
        if ($urandom_range(p2) == 0) mmcm2_locked = ~mmcm2_locked;
        fault_clr = ($urandom_range(39) == 0);
        rst       = ($urandom_range(599) == 0);
        tick();
      end
    end
    rst = 1'b0;
    fault_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
